// File: rtl/rsp_s1_prep_phase_rotate.sv
// Stage-1 prep phase rotator: aligns 4-lane samples with twiddles, complex multiply, round, saturate.
// Optional saturation counter enabled by defining RSP_ROT_SAT_CNT_EN.
module rsp_s1_prep_phase_rotate #(
   parameter int DATA_WIDTH = 16,
   parameter int TW_WIDTH   = 32,
   parameter int TW_FRAC    = 30,
   parameter int TW_LATENCY = 9,
   parameter int FRAME_LEN  = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic                    i_data_valid,
   input  logic                    i_data_last,
   input  logic [8*DATA_WIDTH-1:0] i_data,
   input  logic [8*TW_WIDTH-1:0]   i_w,
   output logic [8*DATA_WIDTH-1:0] o_data,
   output logic                    o_data_valid,
   output logic                    o_data_last,
   output logic                    o_done,
   output logic                    o_frame_err,
   output logic                    o_busy,
   output logic [15:0]             o_sat_cnt
);
   localparam int LANES = 4;
   localparam int BEATS = FRAME_LEN / LANES;
   localparam int CW    = $clog2(BEATS);
   localparam int DCW   = $clog2(TW_LATENCY + 2);
   localparam int PW    = DATA_WIDTH + TW_WIDTH;
   localparam int SW    = PW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [CW-1:0]  LAST_BEAT = CW'(BEATS - 1);
   // done lands on the same cycle as the final output beat
   localparam logic [DCW-1:0] DRAIN_END = DCW'(TW_LATENCY + 1);

   localparam logic signed [SW-1:0] RND  = SW'(1) <<< (TW_FRAC - 1);
   localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (DATA_WIDTH - 1)) - SW'(1);
   localparam logic signed [SW-1:0] MINV = -(SW'(1) <<< (DATA_WIDTH - 1));

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  beat_q, beat_d;
   logic [DCW-1:0] drn_q, drn_d;
   logic           err_q, err_d;
   logic           done_q, done_d;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      drn_d   = drn_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = ST_RUN;
               beat_d  = '0;
               err_d   = 1'b0;
            end else if (i_data_valid) begin
               err_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (i_start) err_d = 1'b1;
            if (i_data_valid) begin
               beat_d = beat_q + CW'(1);
               if (i_data_last != (beat_q == LAST_BEAT)) err_d = 1'b1;
               if (i_data_last || beat_q == LAST_BEAT) begin
                  state_d = ST_DRAIN;
                  drn_d   = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (i_start) err_d = 1'b1;
            drn_d = drn_q + DCW'(1);
            if (drn_q == DRAIN_END) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         drn_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         drn_q   <= drn_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   logic [8*DATA_WIDTH-1:0] dl_data_q [TW_LATENCY];
   logic [TW_LATENCY-1:0]   dl_vld_q, dl_last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_vld_q  <= '0;
         dl_last_q <= '0;
         for (int i = 0; i < TW_LATENCY; i++) dl_data_q[i] <= '0;
      end else begin
         dl_vld_q  <= {dl_vld_q[TW_LATENCY-2:0], i_data_valid};
         dl_last_q <= {dl_last_q[TW_LATENCY-2:0], i_data_valid & i_data_last};
         dl_data_q[0] <= i_data;
         for (int i = 1; i < TW_LATENCY; i++) dl_data_q[i] <= dl_data_q[i-1];
      end
   end

   logic signed [DATA_WIDTH-1:0] di [LANES];
   logic signed [DATA_WIDTH-1:0] dq [LANES];
   logic signed [TW_WIDTH-1:0]   wr [LANES];
   logic signed [TW_WIDTH-1:0]   wi [LANES];
   logic signed [PW-1:0] p_iwr_q [LANES];
   logic signed [PW-1:0] p_qwi_q [LANES];
   logic signed [PW-1:0] p_iwi_q [LANES];
   logic signed [PW-1:0] p_qwr_q [LANES];
   logic signed [SW-1:0] s_i_q [LANES];
   logic signed [SW-1:0] s_q_q [LANES];
   logic signed [SW-1:0] r_i [LANES];
   logic signed [SW-1:0] r_q [LANES];
   logic [8*DATA_WIDTH-1:0] y_d, data_q;
   logic [2*LANES-1:0]      clip;
   logic [1:0]              vld_p_q, last_p_q;
   logic                    vld_q, last_q;

   always_comb begin
      y_d  = '0;
      clip = '0;
      for (int k = 0; k < LANES; k++) begin
         di[k] = signed'(dl_data_q[TW_LATENCY-1][2*DATA_WIDTH*k+DATA_WIDTH +: DATA_WIDTH]);
         dq[k] = signed'(dl_data_q[TW_LATENCY-1][2*DATA_WIDTH*k +: DATA_WIDTH]);
         wr[k] = signed'(i_w[2*TW_WIDTH*k+TW_WIDTH +: TW_WIDTH]);
         wi[k] = signed'(i_w[2*TW_WIDTH*k +: TW_WIDTH]);
         r_i[k] = (s_i_q[k] + RND) >>> TW_FRAC;
         r_q[k] = (s_q_q[k] + RND) >>> TW_FRAC;
         if (r_i[k] > MAXV) begin
            y_d[2*DATA_WIDTH*k+DATA_WIDTH +: DATA_WIDTH] = MAXV[DATA_WIDTH-1:0];
            clip[2*k+1] = 1'b1;
         end else if (r_i[k] < MINV) begin
            y_d[2*DATA_WIDTH*k+DATA_WIDTH +: DATA_WIDTH] = MINV[DATA_WIDTH-1:0];
            clip[2*k+1] = 1'b1;
         end else begin
            y_d[2*DATA_WIDTH*k+DATA_WIDTH +: DATA_WIDTH] = r_i[k][DATA_WIDTH-1:0];
         end
         if (r_q[k] > MAXV) begin
            y_d[2*DATA_WIDTH*k +: DATA_WIDTH] = MAXV[DATA_WIDTH-1:0];
            clip[2*k] = 1'b1;
         end else if (r_q[k] < MINV) begin
            y_d[2*DATA_WIDTH*k +: DATA_WIDTH] = MINV[DATA_WIDTH-1:0];
            clip[2*k] = 1'b1;
         end else begin
            y_d[2*DATA_WIDTH*k +: DATA_WIDTH] = r_q[k][DATA_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LANES; k++) begin
            p_iwr_q[k] <= '0;
            p_qwi_q[k] <= '0;
            p_iwi_q[k] <= '0;
            p_qwr_q[k] <= '0;
            s_i_q[k]   <= '0;
            s_q_q[k]   <= '0;
         end
         vld_p_q  <= '0;
         last_p_q <= '0;
         vld_q    <= 1'b0;
         last_q   <= 1'b0;
         data_q   <= '0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            p_iwr_q[k] <= PW'(di[k]) * PW'(wr[k]);
            p_qwi_q[k] <= PW'(dq[k]) * PW'(wi[k]);
            p_iwi_q[k] <= PW'(di[k]) * PW'(wi[k]);
            p_qwr_q[k] <= PW'(dq[k]) * PW'(wr[k]);
            s_i_q[k]   <= SW'(p_iwr_q[k]) - SW'(p_qwi_q[k]);
            s_q_q[k]   <= SW'(p_iwi_q[k]) + SW'(p_qwr_q[k]);
         end
         vld_p_q  <= {vld_p_q[0], dl_vld_q[TW_LATENCY-1]};
         last_p_q <= {last_p_q[0], dl_last_q[TW_LATENCY-1]};
         vld_q    <= vld_p_q[1];
         last_q   <= last_p_q[1];
         data_q   <= y_d;
      end
   end

`ifdef RSP_ROT_SAT_CNT_EN
   logic [15:0] sat_q;
   logic [3:0]  nclip;
   logic [16:0] sat_sum;
   logic        start_ok;

   assign start_ok = (state_q == ST_IDLE) & i_start;

   always_comb begin
      nclip = '0;
      for (int j = 0; j < 2*LANES; j++) nclip = nclip + 4'(clip[j]);
      sat_sum = {1'b0, sat_q} + 17'(nclip);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          sat_q <= '0;
      else if (start_ok)   sat_q <= '0;
      else if (vld_p_q[1]) sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
   end

   assign o_sat_cnt = sat_q;
`else
   logic sat_unused;
   assign sat_unused = ^clip;
   assign o_sat_cnt  = '0;
`endif

   assign o_data       = data_q;
   assign o_data_valid = vld_q;
   assign o_data_last  = last_q;
   assign o_done       = done_q;
   assign o_frame_err  = err_q;
   assign o_busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
endmodule

// File: tb/tb_rsp_s1_prep_phase_rotate.sv
// Bench for rsp_s1_prep_phase_rotate: per-cycle model compare plus directed literal checks.
// Set RSP_ROT_SAT_CNT_EN to also check the saturation counter.
module tb_rsp_s1_prep_phase_rotate;
   localparam int H = 4096;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_start, i_data_valid, i_data_last;
   logic [127:0] i_data;
   logic [255:0] i_w;
   logic [127:0] o_data;
   logic         o_data_valid, o_data_last, o_done;
   logic         o_frame_err, o_busy;
   logic [15:0]  o_sat_cnt;

   int checks = 0;
   int failures = 0;
   int outs = 0;
   int lasts = 0;

   rsp_s1_prep_phase_rotate dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_data_valid (i_data_valid),
      .i_data_last  (i_data_last),
      .i_data       (i_data),
      .i_w          (i_w),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .o_data_last  (o_data_last),
      .o_done       (o_done),
      .o_frame_err  (o_frame_err),
      .o_busy       (o_busy),
      .o_sat_cnt    (o_sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rot_lane(input logic [31:0] d,
                                            input logic [63:0] w,
                                            output int clips);
      longint si, sq, wr, wi, re, im;
      logic [31:0] r;
      si = longint'($signed(d[31:16]));
      sq = longint'($signed(d[15:0]));
      wr = longint'($signed(w[63:32]));
      wi = longint'($signed(w[31:0]));
      re = (si * wr - sq * wi + (longint'(1) <<< 29)) >>> 30;
      im = (si * wi + sq * wr + (longint'(1) <<< 29)) >>> 30;
      clips = 0;
      if (re > 32767) begin re = 32767; clips++; end
      else if (re < -32768) begin re = -32768; clips++; end
      if (im > 32767) begin im = 32767; clips++; end
      else if (im < -32768) begin im = -32768; clips++; end
      r = {re[15:0], im[15:0]};
      return r;
   endfunction

   function automatic logic [127:0] rot_beat(input logic [127:0] d,
                                             input logic [255:0] w,
                                             output int clips);
      logic [127:0] r;
      int c;
      clips = 0;
      for (int k = 0; k < 4; k++) begin
         r[32*k +: 32] = rot_lane(d[32*k +: 32], w[64*k +: 64], c);
         clips += c;
      end
      return r;
   endfunction

   // reference model state, advanced once per clock edge
   logic [127:0] hist_d [H];
   logic [255:0] hist_w [H];
   logic         hist_v [H];
   logic         hist_l [H];
   int ecnt = 0;
   int flush_e = 0;
   int done_e = -1;
   int m_beats = 0;
   int m_sat = 0;
   bit m_busy = 0, m_drain = 0, m_err = 0;
   bit ex_v = 0, ex_l = 0, ex_done = 0;
   logic [127:0] ex_d = '0;

   always @(posedge clk) begin
      int e, c;
      bit start_ok;
      e = ecnt;
      start_ok = 0;
      c = 0;
      hist_d[e % H] = i_data;
      hist_w[e % H] = i_w;
      hist_v[e % H] = i_data_valid & rst_n;
      hist_l[e % H] = i_data_last;
      if (!rst_n) begin
         m_busy = 0; m_drain = 0; m_err = 0; m_sat = 0;
         done_e = -1; flush_e = e + 1;
      end else if (!m_busy) begin
         if (i_start) begin
            m_busy = 1; m_beats = 0; m_err = 0; start_ok = 1;
         end else if (i_data_valid) m_err = 1;
      end else begin
         if (i_start) m_err = 1;
         if (!m_drain && i_data_valid) begin
            if (i_data_last && m_beats != 255) m_err = 1;
            if (!i_data_last && m_beats == 255) m_err = 1;
            if (i_data_last || m_beats == 255) begin
               m_drain = 1; done_e = e + 11;
            end
            m_beats++;
         end
         if (m_drain && e == done_e) begin
            m_busy = 0; m_drain = 0;
         end
      end
      ex_v = rst_n && e >= 11 && (e - 11) >= flush_e && hist_v[(e-11) % H];
      ex_l = ex_v && hist_l[(e-11) % H];
      ex_d = '0;
      if (ex_v) ex_d = rot_beat(hist_d[(e-11) % H], hist_w[(e-2) % H], c);
      if (rst_n) begin
         if (start_ok) m_sat = 0;
         else if (ex_v) m_sat = (m_sat + c > 65535) ? 65535 : m_sat + c;
      end
      ex_done = rst_n && (e == done_e);
      ecnt++;
   end

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         chk("rst_valid", o_data_valid, 0);
         chk("rst_data", o_data, 0);
         chk("rst_last", o_data_last, 0);
         chk("rst_done", o_done, 0);
         chk("rst_err", o_frame_err, 0);
         chk("rst_busy", o_busy, 0);
         chk("rst_sat", o_sat_cnt, 0);
      end else begin
         chk("valid", o_data_valid, ex_v);
         chk("last", o_data_last, ex_l);
         chk("done", o_done, ex_done);
         chk("busy", o_busy, m_busy);
         chk("frame_err", o_frame_err, m_err);
`ifdef RSP_ROT_SAT_CNT_EN
         chk("sat_cnt", o_sat_cnt, m_sat);
`else
         chk("sat_cnt", o_sat_cnt, 0);
`endif
         if (ex_v) chk("data", o_data, ex_d);
         if (o_data_valid) outs++;
         if (o_data_valid && o_data_last) lasts++;
      end
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [255:0] rnd256();
      return {rnd128(), rnd128()};
   endfunction

   task automatic probe(input string nm, input logic [127:0] d,
                        input logic [255:0] w, input logic [127:0] exp);
      int n;
      i_w = w;
      @(negedge clk);
      i_data = d; i_data_valid = 1;
      @(negedge clk);
      i_data_valid = 0;
      n = 1;
      while (!o_data_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_latency"}, n, 12);
      chk({nm, "_out"}, o_data, exp);
      repeat (2) @(negedge clk);
   endtask

   task automatic run_frame(input int nb, input int last_at, input int dup_at);
      int b;
      b = 0;
      outs = 0;
      lasts = 0;
      @(negedge clk);
      i_start = 1;
      @(negedge clk);
      i_start = 0;
      chk("start_clr_err", o_frame_err, 0);
      chk("start_busy", o_busy, 1);
      while (b < nb) begin
         i_w = rnd256();
         if ($urandom_range(0, 2) != 0) begin
            i_data_valid = 1;
            i_data = rnd128();
            i_data_last = (b == last_at);
            i_start = (b == dup_at);
            b++;
         end else begin
            i_data_valid = 0; i_data_last = 0; i_start = 0;
         end
         @(negedge clk);
      end
      i_data_valid = 0; i_data_last = 0; i_start = 0;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (!o_done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_done_seen"}, o_done, 1);
   endtask

   initial begin
      logic [31:0] r;
      int c;
      rst_n = 0; i_start = 0; i_data_valid = 0; i_data_last = 0;
      i_data = '0; i_w = '0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("reset_err", o_frame_err, 0);
      chk("reset_busy", o_busy, 0);

      r = rot_lane(32'h1000_0800, 64'h40000000_00000000, c);
      chk("pin_ident", r, 32'h1000_0800);
      r = rot_lane(32'h1000_0800, 64'h00000000_40000000, c);
      chk("pin_rot90", r, 32'hF800_1000);
      r = rot_lane(32'h7FFF_7FFF, 64'h40000000_40000000, c);
      chk("pin_sat", r, 32'h0000_7FFF);
      chk("pin_sat_clips", c, 1);
      r = rot_lane(32'h8000_8000, 64'h40000000_40000000, c);
      chk("pin_negsat", r, 32'h0000_8000);
      r = rot_lane(32'h0001_0000, 64'h20000000_00000000, c);
      chk("pin_round_up", r, 32'h0001_0000);
      r = rot_lane(32'hFFFF_0000, 64'h20000000_00000000, c);
      chk("pin_round_neg", r, 32'h0000_0000);

      probe("ident", {4{32'h1000_0800}}, {4{64'h40000000_00000000}},
            {4{32'h1000_0800}});
      probe("rot90", {4{32'h1000_0800}}, {4{64'h00000000_40000000}},
            {4{32'hF800_1000}});
      probe("sat", {4{32'h7FFF_7FFF}}, {4{64'h40000000_40000000}},
            {4{32'h0000_7FFF}});
`ifdef RSP_ROT_SAT_CNT_EN
      chk("sat_cnt_lit", o_sat_cnt, 4);
`endif
      chk("idle_beat_err", o_frame_err, 1);

      run_frame(256, 255, -1);
      wait_done("full");
      chk("full_outs", outs, 256);
      chk("full_lasts", lasts, 1);
      chk("full_err", o_frame_err, 0);

      run_frame(101, 100, -1);
      wait_done("early");
      chk("early_outs", outs, 101);
      chk("early_err", o_frame_err, 1);
      @(negedge clk);
      chk("early_idle", o_busy, 0);

      run_frame(256, -1, -1);
      wait_done("nolast");
      chk("nolast_outs", outs, 256);
      chk("nolast_lasts", lasts, 0);
      chk("nolast_err", o_frame_err, 1);

      run_frame(50, -1, 30);
      chk("dup_start_err", o_frame_err, 1);
      chk("mid_busy", o_busy, 1);
      rst_n = 0;
      @(negedge clk);
      chk("mid_rst_valid", o_data_valid, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_err", o_frame_err, 0);
      rst_n = 1;
      outs = 0;
      repeat (20) @(negedge clk);
      chk("mid_rst_no_out", outs, 0);
      chk("mid_rst_idle", o_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
